// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder and its storage array.
`timescale 1ns/1ps
package dm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] DM_BASE = 32'h0000_0000;

  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

  // Word aligned and inside the populated range; high addresses never alias.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word storage with a registered read port and a byte-masked write port.
`timescale 1ns/1ps
module dm_array
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata,
  output logic [31:0]   o_merged
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  assign w_merged = be_merge(r_mem[i_addr], i_wdata, i_be);
  assign o_merged = w_merged;
  assign o_rdata  = r_rdata;

  // NOTE: the whole array is cleared by reset because software relies on zeroed
  // memory after reset; this rules out a plain RAM macro for this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= w_merged;
        r_rdata       <= '0;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Load/store memory slave: one request at a time, response after LATENCY cycles.
`timescale 1ns/1ps
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned LATENCY     = 2,
  parameter bit          TRACE_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_pc;
  logic        r_resp_valid;
  logic        r_resp_err;

  logic          w_in_idle;
  logic          w_accept;
  logic          w_commit;
  logic          w_c_we;
  logic [31:0]   w_c_addr;
  logic [31:0]   w_c_wdata;
  logic [3:0]    w_c_be;
  logic [31:0]   w_c_pc;
  logic [31:0]   w_offs;
  logic          w_ok;
  logic [31:0]   w_arr_rdata;
  logic [31:0]   w_merged;

  assign w_in_idle = (r_state == IDLE);
  assign req_ready = w_in_idle && !reset;
  assign w_accept  = w_in_idle && req_valid;

  // A single-cycle build commits on the accept edge, so it must use the live request.
  assign w_c_we    = w_in_idle ? req_we    : r_we;
  assign w_c_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_c_wdata = w_in_idle ? req_wdata : r_wdata;
  assign w_c_be    = w_in_idle ? req_be    : r_be;
  assign w_c_pc    = w_in_idle ? req_pc    : r_pc;

  assign w_commit = ((LATENCY == 1) && w_accept) ||
                    ((r_state == WAIT) && (r_count == 4'd1));
  assign w_offs   = w_c_addr - DM_BASE;
  assign w_ok     = addr_ok(w_offs, DEPTH_WORDS);

  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_commit && w_ok),
    .i_we     (w_c_we),
    .i_addr   (w_offs[AW+1:2]),
    .i_wdata  (w_c_wdata),
    .i_be     (w_c_be),
    .o_rdata  (w_arr_rdata),
    .o_merged (w_merged)
  );

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_err ? 32'h0 : w_arr_rdata;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_pc         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_pc    <= req_pc;
            r_count <= CNT_LOAD;
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= !w_ok;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_ok;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if (TRACE_EN) begin : g_trace
    always_ff @(posedge clk) begin
      if (!reset && w_commit && w_ok && w_c_we && (w_c_be != 4'h0))
        $write("%d@%h: *%h <= %h\n", $time, w_c_pc, w_c_addr, w_merged);
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Table-driven bench for dm_responder across LATENCY = 2, 3, 1 and 15 builds.
`timescale 1ns/1ps
module tb_dm_responder;

  localparam int ND = 4;

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid  [ND];
  logic        req_we     [ND];
  logic [31:0] req_addr   [ND];
  logic [31:0] req_wdata  [ND];
  logic [3:0]  req_be     [ND];
  logic [31:0] req_pc     [ND];
  logic        resp_ready [ND];
  wire         req_ready  [ND];
  wire         resp_valid [ND];
  wire  [31:0] resp_rdata [ND];
  wire         resp_err   [ND];

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_acc [ND];
  exp_t sb [$];
  vec_t tbl [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dm_responder #(
      .DEPTH_WORDS (3072),
      .LATENCY     (g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : 15),
      .TRACE_EN    (g == 0 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .req_pc     (req_pc[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic vec_t mk(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int hold);
    vec_t v;
    v.d = d; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.hold = hold;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input vec_t v);
    int   d;
    int   n;
    exp_t e;
    d = v.d;
    @(negedge clk);
    req_we[d]     = v.we;
    req_addr[d]   = v.addr;
    req_wdata[d]  = v.wdata;
    req_be[d]     = v.be;
    req_pc[d]     = 32'h0040_0000 + 32'(cyc * 4);
    resp_ready[d] = (v.hold == 0);
    req_valid[d]  = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("req_ready dut%0d", d), 32'(req_ready[d]), 32'd1);
    if (last_acc[d] >= 0)
      check($sformatf("accept_gap dut%0d", d),
            32'((cyc - last_acc[d]) >= (lat_of(d) + 1)), 32'd1);
    last_acc[d] = cyc;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("resp_valid dut%0d", d), 32'(resp_valid[d]), 32'd1);
    check($sformatf("latency dut%0d", d), 32'(n), 32'(lat_of(d)));
    e = sb.pop_front();
    check($sformatf("rdata dut%0d @%h", d, v.addr), resp_rdata[d], e.rdata);
    check($sformatf("err dut%0d @%h", d, v.addr), 32'(resp_err[d]), 32'(e.err));
    if (v.hold > 0) begin
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        check("bp resp_valid", 32'(resp_valid[d]), 32'd1);
        check("bp rdata", resp_rdata[d], e.rdata);
        check("bp req_ready", 32'(req_ready[d]), 32'd0);
      end
      resp_ready[d] = 1'b1;
      @(negedge clk);
      check("bp release resp_valid", 32'(resp_valid[d]), 32'd0);
      check("bp release req_ready", 32'(req_ready[d]), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      req_be[d] = '0; req_pc[d] = '0; resp_ready[d] = 1'b1; last_acc[d] = -1;
    end

    tbl.push_back(mk(0, 1, 32'h10,   32'h1234_5678, 4'hF, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 32'h10,   32'h0,         4'h0, 32'h1234_5678, 0, 0));
    tbl.push_back(mk(0, 1, 32'h20,   32'hAABB_CCDD, 4'hF, 32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 32'h20,   32'h1122_3344, 4'h5, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 32'h20,   32'h0,         4'h0, 32'hAA22_CC44, 0, 0));
    tbl.push_back(mk(0, 1, 32'h24,   32'h5566_7788, 4'hA, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 32'h24,   32'h0,         4'h0, 32'h5500_7700, 0, 0));
    tbl.push_back(mk(0, 0, 32'h13,   32'h0,         4'h0, 32'h0,         1, 0));
    tbl.push_back(mk(0, 1, 32'h3000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1, 0));
    tbl.push_back(mk(0, 1, 32'h22,   32'hFFFF_FFFF, 4'hF, 32'h0,         1, 0));
    tbl.push_back(mk(0, 0, 32'h20,   32'h0,         4'h0, 32'hAA22_CC44, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    32'h0,         4'h0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 32'h10,   32'hFFFF_FFFF, 4'h0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 32'h10,   32'h0,         4'h0, 32'h1234_5678, 0, 5));
    tbl.push_back(mk(0, 1, 32'h2FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 32'h2FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 0, 0));
    tbl.push_back(mk(0, 0, 32'hFFFF_FFFC, 32'h0,    4'h0, 32'h0,         1, 0));
    tbl.push_back(mk(1, 0, 32'h40,   32'h0,         4'h0, 32'h0,         0, 0));
    for (int d = 2; d < ND; d++) begin
      tbl.push_back(mk(d, 1, 32'h8, 32'h0102_0304, 4'hF, 32'h0,         0, 0));
      tbl.push_back(mk(d, 0, 32'h8, 32'h0,         4'h0, 32'h0102_0304, 0, 0));
      tbl.push_back(mk(d, 0, 32'h8, 32'h0,         4'h0, 32'h0102_0304, 0, 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready[0]), 32'd0);
    check("reset resp_valid", 32'(resp_valid[0]), 32'd0);
    check("reset resp_rdata", resp_rdata[0], 32'h0);
    check("reset resp_err", 32'(resp_err[0]), 32'd0);
    reset = 1'b0;
    #1;
    check("post-reset req_ready", 32'(req_ready[0]), 32'd1);

    foreach (tbl[i]) do_req(tbl[i]);

    // Hold a response on dut0 while dut1 (LATENCY=3) has a store in flight, then reset.
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[0] = 32'h10; resp_ready[0] = 1'b0; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_we[1] = 1'b1; req_addr[1] = 32'h40; req_wdata[1] = 32'hDEAD_BEEF;
    req_be[1] = 4'hF; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("midop dut0 resp_valid", 32'(resp_valid[0]), 32'd1);
    check("midop dut1 req_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset drops resp_valid", 32'(resp_valid[0]), 32'd0);
    check("reset req_ready dut1", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp_ready[0] = 1'b1;
    #1;
    check("release req_ready dut1", 32'(req_ready[1]), 32'd1);
    last_acc[0] = -1;
    last_acc[1] = -1;
    do_req(mk(1, 0, 32'h40, 32'h0, 4'h0, 32'h0, 0, 0));
    do_req(mk(0, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
